// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and default widths for the cacheline burst adaptor.
package cacheline_burst_adaptor_pkg;

  localparam int CLA_LINE_W  = 256;  // cacheline width in bits
  localparam int CLA_BURST_W = 64;   // memory bus beat width in bits
  localparam int CLA_ADDR_W  = 32;   // address width

  // Line-transfer controller states.
  typedef enum logic [1:0] {
    cla_idle,
    cla_read,
    cla_write,
    cla_done
  } cla_states;

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Bus bundles around the adaptor: the line-level handshake towards
// ewb_control and the burst-level bus towards physical memory.

// Line side. master = requester (ewb_control), slave = adaptor.
interface cacheline_burst_adaptor_line_if
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int LINE_W = CLA_LINE_W,
  parameter int ADDR_W = CLA_ADDR_W
) ();

  logic [LINE_W-1:0] line_i;     // line to write
  logic [LINE_W-1:0] line_o;     // line returned by last completed read
  logic [ADDR_W-1:0] address_i;  // line address
  logic              read_i;     // line read request, held until resp_o
  logic              write_i;    // line write request, held until resp_o
  logic              resp_o;     // one-cycle completion pulse

  modport master (
    output line_i, address_i, read_i, write_i,
    input  line_o, resp_o
  );

  modport slave (
    input  line_i, address_i, read_i, write_i,
    output line_o, resp_o
  );

endinterface

// Memory side. master = adaptor, slave = memory model.
interface cacheline_burst_adaptor_mem_if
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int BURST_W = CLA_BURST_W,
  parameter int ADDR_W  = CLA_ADDR_W
) ();

  logic [BURST_W-1:0] burst_i;    // read beat from memory
  logic [BURST_W-1:0] burst_o;    // write beat to memory
  logic [ADDR_W-1:0]  address_o;  // line-aligned burst address
  logic               read_o;     // burst read, held for the whole burst
  logic               write_o;    // burst write, held for the whole burst
  logic               resp_i;     // one per beat: beat valid / accepted

  modport master (
    output burst_o, address_o, read_o, write_o,
    input  burst_i, resp_i
  );

  modport slave (
    input  burst_o, address_o, read_o, write_o,
    output burst_i, resp_i
  );

endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Cacheline burst adaptor: turns whole-line read/write requests into
// fixed-length bursts of BEATS beats on the memory bus, beat 0 = line LSBs.
module cacheline_burst_adaptor
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int LINE_W  = CLA_LINE_W,
  parameter int BURST_W = CLA_BURST_W,
  parameter int ADDR_W  = CLA_ADDR_W
) (
  input  logic                                 clk,
  input  logic                                 reset,
  cacheline_burst_adaptor_line_if.slave        line_bus,
  cacheline_burst_adaptor_mem_if.master        mem_bus
);

  localparam int BEATS    = LINE_W / BURST_W;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  cla_states          state;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   next_count;
  logic [LINE_W-1:0]  wr_line;       // write line captured at accept
  logic [LINE_W-1:0]  rd_line;       // read line, drives line_o
  logic [ADDR_W-1:0]  addr_q;        // line-aligned burst address
  logic [ADDR_W-1:0]  aligned_addr;
  logic [BURST_W-1:0] burst_q;
  logic               resp_q;
  logic               read_q;
  logic               write_q;

  assign next_count   = count + CNT_W'(1);
  assign aligned_addr = {line_bus.address_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

  // Byte-offset bits of the request address play no part: bursts are line aligned.
  logic unused_offset;
  assign unused_offset = ^line_bus.address_i[OFFSET_W-1:0];

  // Line-transfer FSM: accept a request, run the burst beat by beat, pulse resp.
  // NOTE: the line buffers sit under reset with the control state, because
  // line_o and burst_o are defined to read zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= cla_idle;
      count   <= '0;
      wr_line <= '0;
      rd_line <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      resp_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here so each register samples the
      // pre-edge value of count/state regardless of statement order.
      case (state)
        cla_idle: begin
          // Write wins when both requests are up; resp_i is ignored here.
          if (line_bus.write_i) begin
            state   <= cla_write;
            write_q <= 1'b1;
            wr_line <= line_bus.line_i;
            burst_q <= line_bus.line_i[BURST_W-1:0];
            addr_q  <= aligned_addr;
            count   <= '0;
          end else if (line_bus.read_i) begin
            state  <= cla_read;
            read_q <= 1'b1;
            addr_q <= aligned_addr;
            count  <= '0;
          end
        end

        cla_read: begin
          if (mem_bus.resp_i) begin
            rd_line[count*BURST_W +: BURST_W] <= mem_bus.burst_i;
            if (count == LAST_BEAT) begin
              state  <= cla_done;
              count  <= '0;
              read_q <= 1'b0;
              resp_q <= 1'b1;
            end else begin
              count <= next_count;
            end
          end
        end

        cla_write: begin
          if (mem_bus.resp_i) begin
            if (count == LAST_BEAT) begin
              state   <= cla_done;
              count   <= '0;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              burst_q <= '0;
            end else begin
              count   <= next_count;
              burst_q <= wr_line[next_count*BURST_W +: BURST_W];
            end
          end
        end

        cla_done: begin
          // Requester drops its request after seeing resp, so IDLE is safe.
          resp_q <= 1'b0;
          state  <= cla_idle;
        end

        default: state <= cla_idle;
      endcase
    end
  end

  assign line_bus.line_o   = rd_line;
  assign line_bus.resp_o   = resp_q;
  assign mem_bus.burst_o   = burst_q;
  assign mem_bus.address_o = addr_q;
  assign mem_bus.read_o    = read_q;
  assign mem_bus.write_o   = write_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench for cacheline_burst_adaptor: table-driven line
// transfers, hand-written stall/reset/back-to-back sequences and random
// transfers checked against a line-level reference model.
module tb_cacheline_burst_adaptor;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;

  logic clk;
  logic reset;

  cacheline_burst_adaptor_line_if line_bus ();
  cacheline_burst_adaptor_mem_if  mem_bus ();

  cacheline_burst_adaptor dut (
    .clk      (clk),
    .reset    (reset),
    .line_bus (line_bus),
    .mem_bus  (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int resp_pulses = 0;

  // Reference model of line_o: last line delivered by a completed read.
  logic [LINE_W-1:0] shadow_line = '0;

  // Counts cycles in which resp_o is high; a stretched pulse counts twice.
  always @(negedge clk) if (line_bus.resp_o === 1'b1) resp_pulses++;

  typedef struct {
    bit                wr;
    bit                rd;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wline;     // line presented for writes
    logic [LINE_W-1:0] rbeats;    // memory read beat k at [k*64 +: 64]
    logic [15:0]       gaps;      // idle cycles before beat k in nibble k
    logic [ADDR_W-1:0] exp_addr;
    bit                exp_wr;    // 1: write burst expected, 0: read burst
    logic [LINE_W-1:0] exp_line;  // expected line_o (read rows only)
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One full line transfer from request to the idle cycle after resp_o.
  task automatic run_txn(input string tag, input bit wr, input bit rd,
                         input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wline,
                         input logic [LINE_W-1:0] rbeats, input logic [15:0] gaps,
                         input logic [ADDR_W-1:0] exp_addr, input bit exp_wr,
                         input logic [LINE_W-1:0] exp_line);
    int k;
    int g;
    line_bus.write_i   = wr;
    line_bus.read_i    = rd;
    line_bus.address_i = addr;
    line_bus.line_i    = wline;
    mem_bus.resp_i     = 1'b0;
    step();  // request accepted
    k = 0;
    g = 0;
    while (k < BEATS) begin
      // Anything the requester changes after accept must be ignored.
      line_bus.address_i = $urandom;
      line_bus.line_i    = rand_line();
      check($sformatf("%s read_o b%0d", tag, k), 256'(mem_bus.read_o), 256'(!exp_wr));
      check($sformatf("%s write_o b%0d", tag, k), 256'(mem_bus.write_o), 256'(exp_wr));
      check($sformatf("%s address_o b%0d", tag, k), 256'(mem_bus.address_o), 256'(exp_addr));
      check($sformatf("%s early resp_o b%0d", tag, k), 256'(line_bus.resp_o), 256'(0));
      if (exp_wr)
        check($sformatf("%s burst_o b%0d", tag, k), 256'(mem_bus.burst_o), 256'(wline[k*BURST_W +: BURST_W]));
      if (g < int'(gaps[k*4 +: 4])) begin
        mem_bus.resp_i  = 1'b0;
        mem_bus.burst_i = {$urandom, $urandom};
        g++;
      end else begin
        mem_bus.resp_i  = 1'b1;
        mem_bus.burst_i = rbeats[k*BURST_W +: BURST_W];
        k++;
        g = 0;
      end
      step();
    end
    mem_bus.resp_i = 1'b0;
    if (!exp_wr) shadow_line = exp_line;
    check({tag, " resp_o"}, 256'(line_bus.resp_o), 256'(1));
    check({tag, " done read_o"}, 256'(mem_bus.read_o), 256'(0));
    check({tag, " done write_o"}, 256'(mem_bus.write_o), 256'(0));
    check({tag, " line_o"}, line_bus.line_o, shadow_line);
    step();
    line_bus.read_i  = 1'b0;
    line_bus.write_i = 1'b0;
    check({tag, " resp_o width"}, 256'(line_bus.resp_o), 256'(0));
    // Stray beat while idle must not be taken.
    mem_bus.resp_i  = 1'b1;
    mem_bus.burst_i = {$urandom, $urandom};
    step();
    mem_bus.resp_i = 1'b0;
    check({tag, " idle read_o"}, 256'(mem_bus.read_o), 256'(0));
    check({tag, " idle write_o"}, 256'(mem_bus.write_o), 256'(0));
    check({tag, " idle line_o"}, line_bus.line_o, shadow_line);
  endtask

  initial begin
    logic [LINE_W-1:0] wl;
    logic [LINE_W-1:0] rl;
    logic [ADDR_W-1:0] a;
    logic [15:0]       gp;
    int                sel;
    int                p0;

    vecs[0] = '{wr: 1'b0, rd: 1'b1, addr: 32'h1234_5678, wline: '0,
                rbeats: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                gaps: 16'h0000, exp_addr: 32'h1234_5660, exp_wr: 1'b0,
                exp_line: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
    vecs[1] = '{wr: 1'b1, rd: 1'b0, addr: 32'h8000_0040,
                wline: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                        64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                rbeats: '0, gaps: 16'h0000, exp_addr: 32'h8000_0040, exp_wr: 1'b1,
                exp_line: '0};
    vecs[2] = '{wr: 1'b1, rd: 1'b1, addr: 32'h0000_001F,
                wline: 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0,
                rbeats: '0, gaps: 16'h0000, exp_addr: 32'h0000_0000, exp_wr: 1'b1,
                exp_line: '0};
    vecs[3] = '{wr: 1'b0, rd: 1'b1, addr: 32'hFFFF_FFFF,
                rbeats: {64'hA0A0_0000_0000_000A, 64'hB0B0_0000_0000_000B,
                         64'hC0C0_0000_0000_000C, 64'hD0D0_0000_0000_000D},
                wline: '0, gaps: 16'h1111, exp_addr: 32'hFFFF_FFE0, exp_wr: 1'b0,
                exp_line: 256'hA0A000000000000A_B0B000000000000B_C0C000000000000C_D0D000000000000D};
    vecs[4] = '{wr: 1'b1, rd: 1'b0, addr: 32'hABCD_EF3F,
                wline: 256'h1000000000000004_2000000000000003_3000000000000002_4000000000000001,
                rbeats: '0, gaps: 16'h0203, exp_addr: 32'hABCD_EF20, exp_wr: 1'b1,
                exp_line: '0};

    // Reset state, asserted away from any clock edge.
    reset = 1'b0;
    line_bus.read_i = 1'b0;
    line_bus.write_i = 1'b0;
    line_bus.address_i = '0;
    line_bus.line_i = '0;
    mem_bus.resp_i = 1'b0;
    mem_bus.burst_i = '0;
    #2 reset = 1'b1;
    #1;
    check("reset resp_o", 256'(line_bus.resp_o), 256'(0));
    check("reset read_o", 256'(mem_bus.read_o), 256'(0));
    check("reset write_o", 256'(mem_bus.write_o), 256'(0));
    check("reset burst_o", 256'(mem_bus.burst_o), 256'(0));
    check("reset address_o", 256'(mem_bus.address_o), 256'(0));
    check("reset line_o", line_bus.line_o, 256'(0));
    step();
    step();
    @(negedge clk) reset = 1'b0;
    step();

    // Table rows: plain read, plain write, both requests, stalled edges.
    for (int i = 0; i < 5; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr,
              vecs[i].wline, vecs[i].rbeats, vecs[i].gaps, vecs[i].exp_addr,
              vecs[i].exp_wr, vecs[i].exp_line);

    // Stalled read: three idle cycles between beats 1 and 2.
    run_txn("stall", 1'b0, 1'b1, 32'h0000_1000, '0,
            {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
             64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101},
            16'h0300, 32'h0000_1000, 1'b0,
            256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101);

    // Reset in the middle of a write, after three beats have gone out.
    p0 = resp_pulses;
    wl = rand_line();
    line_bus.write_i = 1'b1;
    line_bus.address_i = 32'h0000_2040;
    line_bus.line_i = wl;
    step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst burst_o b%0d", k), 256'(mem_bus.burst_o), 256'(wl[k*BURST_W +: BURST_W]));
      mem_bus.resp_i = 1'b1;
      step();
    end
    mem_bus.resp_i = 1'b0;
    check("rst pre write_o", 256'(mem_bus.write_o), 256'(1));
    @(negedge clk) reset = 1'b1;
    #1;
    check("rst write_o", 256'(mem_bus.write_o), 256'(0));
    check("rst burst_o", 256'(mem_bus.burst_o), 256'(0));
    check("rst address_o", 256'(mem_bus.address_o), 256'(0));
    check("rst line_o", line_bus.line_o, 256'(0));
    shadow_line = '0;
    line_bus.write_i = 1'b0;
    step();
    step();
    @(negedge clk) reset = 1'b0;
    step();
    check("rst no resp", 256'(resp_pulses - p0), 256'(0));
    check("rst idle write_o", 256'(mem_bus.write_o), 256'(0));
    rl = rand_line();
    run_txn("post-rst", 1'b0, 1'b1, 32'h0000_3000, '0, rl, 16'h0000, 32'h0000_3000, 1'b0, rl);

    // Back-to-back write then read: exactly two resp pulses, no third burst.
    p0 = resp_pulses;
    wl = rand_line();
    rl = rand_line();
    run_txn("b2b wr", 1'b1, 1'b0, 32'h0000_4000, wl, '0, 16'h0000, 32'h0000_4000, 1'b1, '0);
    run_txn("b2b rd", 1'b0, 1'b1, 32'h0000_5000, '0, rl, 16'h0000, 32'h0000_5000, 1'b0, rl);
    step();
    step();
    check("b2b pulses", 256'(resp_pulses - p0), 256'(2));
    check("b2b quiet read_o", 256'(mem_bus.read_o), 256'(0));
    check("b2b quiet write_o", 256'(mem_bus.write_o), 256'(0));

    // Random transfers against the line-level model.
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 2);
      a   = $urandom;
      wl  = rand_line();
      rl  = rand_line();
      for (int k = 0; k < BEATS; k++) gp[k*4 +: 4] = 4'($urandom_range(0, 2));
      run_txn($sformatf("rnd%0d", n), sel != 0, sel != 1, a, wl, rl, gp,
              a - (a % 32), sel != 0, rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
